// File: rtl/top_entity_pkg.sv
// top_entity_pkg: shared types and defaults for the top_entity stream monitor.
//   DATA_W          - stream value width (64-bit two's complement)
//   DefQueueDepth   - default event-queue depth
//   DefPeriodCycles - default clock cycles between periodic ticks
//   q_entry_t       - one queue slot: {has_event, data, has_tick}
package top_entity_pkg;

  localparam int unsigned DATA_W          = 64;
  localparam int unsigned DefQueueDepth   = 4;
  localparam int unsigned DefPeriodCycles = 500;

  typedef struct packed {
    logic              has_event;
    logic [DATA_W-1:0] data;
    logic              has_tick;
  } q_entry_t;

endpackage

// File: rtl/top_entity_event_queue.sv
// event_queue: FIFO of monitor slots with synchronous active-high reset.
// Optional build macro TOPENTITY_DROP_OLDEST_EN: a push into a full queue (without a
// simultaneous pop) evicts the oldest entry instead of being refused.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   push, wdata - push request and entry to store
//   pop         - pop request (ignored when empty)
//   rdata       - head entry (valid when not empty)
//   empty       - queue holds no entries
//   push_valid  - this cycle's push is stored
module event_queue
  import top_entity_pkg::*;
#(
  parameter int unsigned Depth = DefQueueDepth
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  q_entry_t wdata,
  input  logic     pop,
  output q_entry_t rdata,
  output logic     empty,
  output logic     push_valid
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  q_entry_t        mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full, do_pop, do_push, drop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    full   = (count_q == CntW'(Depth));
    empty  = (count_q == '0);
    do_pop = pop & ~empty;
`ifdef TOPENTITY_DROP_OLDEST_EN
    do_push = push;
    // Full and nothing leaving: overwrite the oldest slot and advance the head past it.
    drop    = push & full & ~do_pop;
`else
    do_push = push & (~full | do_pop);
    drop    = 1'b0;
`endif
    push_valid = do_push;
    rdata      = mem_q[rd_ptr_q];
    rd_ptr_d   = (do_pop | drop) ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d   = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d    = count_q;
    if (do_push && !(do_pop || drop)) begin
      count_d = count_q + CntW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/top_entity.sv
// top_entity: stream monitor with event input in0, event output out0 = in0 + out1.hold(0)
// and periodic output out1 = out0.hold(0) + 1. Events and ticks are queued as slots and run
// through pop -> stage 1 (out0) -> stage 2 (out1) -> presentation, one slot per 3 cycles.
// Optional build macro TOPENTITY_DROP_OLDEST_EN selects drop-oldest on a full queue.
// Ports:
//   clk, rst, en                - clock, synchronous active-high reset, global enable
//   input_0, new_input_0        - input value and event strobe
//   output_0/_1, *_aktv         - held stream values and one-cycle "evaluated" flags
//   q_push, q_push_valid        - push requested / accepted
//   q_pop, q_pop_valid          - pop requested / popped entry valid
//   enable_in0/out0/out1        - per-stream evaluation strobes
module top_entity
  import top_entity_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH   = DefQueueDepth,
  parameter int unsigned PERIOD_CYCLES = DefPeriodCycles
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] input_0,
  input  logic                     new_input_0,
  output logic signed [DATA_W-1:0] output_0,
  output logic                     output_0_aktv,
  output logic signed [DATA_W-1:0] output_1,
  output logic                     output_1_aktv,
  output logic                     q_push,
  output logic                     q_pop,
  output logic                     q_push_valid,
  output logic                     q_pop_valid,
  output logic                     enable_in0,
  output logic                     enable_out0,
  output logic                     enable_out1
);

  localparam int unsigned TickW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

  logic                     act, tick, q_empty, pipe_empty;
  logic [TickW-1:0]         tick_cnt_q, tick_cnt_d;
  q_entry_t                 push_entry, head;
  q_entry_t                 s1_q, s1_d;
  logic                     s1_valid_q, s1_valid_d;
  // Every slot carries at least one flag, so stages 2/3 need no separate valid bit.
  logic                     s2_event_q, s2_event_d, s2_tick_q, s2_tick_d;
  logic                     s3_event_q, s3_event_d, s3_tick_q, s3_tick_d;
  logic signed [DATA_W-1:0] out0_q, out0_d, out1_q, out1_d;

  event_queue #(
    .Depth(QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .wdata     (push_entry),
    .pop       (q_pop),
    .rdata     (head),
    .empty     (q_empty),
    .push_valid(q_push_valid)
  );

  always_comb begin
    act        = en & ~rst;
    tick       = (tick_cnt_q == TickW'(PERIOD_CYCLES - 1));
    q_push     = act & (new_input_0 | tick);
    push_entry = '{has_event: new_input_0, data: input_0, has_tick: tick};
    pipe_empty = ~s1_valid_q & ~(s2_event_q | s2_tick_q);
    q_pop      = act & ~q_empty & pipe_empty;
    q_pop_valid = q_pop;

    tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
    s1_valid_d = q_pop;
    s1_d       = head;
    s2_event_d = s1_valid_q & s1_q.has_event;
    s2_tick_d  = s1_valid_q & s1_q.has_tick;
    s3_event_d = s2_event_q;
    s3_tick_d  = s2_tick_q;

    // in0 itself has no reader beyond out0, so it is consumed straight from the slot.
    out0_d = out0_q;
    if (s1_valid_q && s1_q.has_event) begin
      out0_d = s1_q.data + out1_q;
    end
    // Stage 2 sees the out0 written by stage 1 of the same slot.
    out1_d = out1_q;
    if (s2_tick_q) begin
      out1_d = out0_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_event_q <= 1'b0;
      s2_tick_q  <= 1'b0;
      s3_event_q <= 1'b0;
      s3_tick_q  <= 1'b0;
      out0_q     <= '0;
      out1_q     <= '0;
    end else if (en) begin
      tick_cnt_q <= tick_cnt_d;
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_event_q <= s2_event_d;
      s2_tick_q  <= s2_tick_d;
      s3_event_q <= s3_event_d;
      s3_tick_q  <= s3_tick_d;
      out0_q     <= out0_d;
      out1_q     <= out1_d;
    end
  end

  always_comb begin
    enable_in0    = act & s1_valid_q & s1_q.has_event;
    enable_out0   = enable_in0;
    enable_out1   = act & s2_tick_q;
    output_0_aktv = act & s3_event_q;
    output_1_aktv = act & s3_tick_q;
    output_0      = out0_q;
    output_1      = out1_q;
  end

endmodule

// File: tb/tb_top_entity.sv
module tb_top_entity;
  import top_entity_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PERIOD = 500;

  logic               clk, rst, en, new_input_0;
  logic signed [63:0] input_0, output_0, output_1;
  logic output_0_aktv, output_1_aktv, q_push, q_pop, q_push_valid, q_pop_valid;
  logic enable_in0, enable_out0, enable_out1;

  top_entity #(
    .QUEUE_DEPTH  (DEPTH),
    .PERIOD_CYCLES(PERIOD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .input_0      (input_0),
    .new_input_0  (new_input_0),
    .output_0     (output_0),
    .output_0_aktv(output_0_aktv),
    .output_1     (output_1),
    .output_1_aktv(output_1_aktv),
    .q_push       (q_push),
    .q_pop        (q_pop),
    .q_push_valid (q_push_valid),
    .q_pop_valid  (q_pop_valid),
    .enable_in0   (enable_in0),
    .enable_out0  (enable_out0),
    .enable_out1  (enable_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a FIFO of slots plus a list of slots in flight, each tagged with the
  // enabled-cycle index at which it was popped. Age 1 = out0 evaluated, age 2 = out1
  // evaluated, age 3 = presented.
  typedef struct {
    q_entry_t ent;
    int       pop_e;
  } flight_t;

  q_entry_t    mq[$];
  flight_t     fl[$];
  logic [63:0] m_o0, m_o1;
  int          m_cnt, m_e;
  int          n_tests, n_fail;
  logic        l_a0, l_a1;
  logic [63:0] l_o0, l_o1;
  int          a0_cnt, a1_cnt, en0_cnt;
  logic        saw_drop;
  logic        r_l, e_l, nv_l;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic nv, input logic [63:0] d);
    logic     tk, x_push, x_pushv, x_pop, x_in0, x_out1, x_a0, x_a1, pe;
    int       age;
    flight_t  keep[$];
    flight_t  f;
    q_entry_t ent;
    rst = r; en = e; new_input_0 = nv; input_0 = d;
    @(negedge clk);
    tk = 0; x_push = 0; x_pushv = 0; x_pop = 0; x_in0 = 0; x_out1 = 0; x_a0 = 0; x_a1 = 0;
    if (!r && e) begin
      tk = (m_cnt == int'(PERIOD) - 1);
      x_push = nv | tk;
      pe = 1;
      foreach (fl[i]) begin
        age = m_e - fl[i].pop_e;
        if (age == 1) begin pe = 0; x_in0 = fl[i].ent.has_event; end
        if (age == 2) begin pe = 0; x_out1 = fl[i].ent.has_tick; end
        if (age == 3) begin x_a0 = fl[i].ent.has_event; x_a1 = fl[i].ent.has_tick; end
      end
      x_pop = (mq.size() != 0) && pe;
`ifdef TOPENTITY_DROP_OLDEST_EN
      x_pushv = x_push;
`else
      x_pushv = x_push && ((mq.size() < int'(DEPTH)) || x_pop);
`endif
    end
    chk("q_push", q_push, x_push);
    chk("q_push_valid", q_push_valid, x_pushv);
    chk("q_pop", q_pop, x_pop);
    chk("q_pop_valid", q_pop_valid, x_pop);
    chk("enable_in0", enable_in0, x_in0);
    chk("enable_out0", enable_out0, x_in0);
    chk("enable_out1", enable_out1, x_out1);
    chk("output_0_aktv", output_0_aktv, x_a0);
    chk("output_1_aktv", output_1_aktv, x_a1);
    chk("output_0", output_0, m_o0);
    chk("output_1", output_1, m_o1);
    l_a0 = output_0_aktv; l_a1 = output_1_aktv; l_o0 = output_0; l_o1 = output_1;
    a0_cnt += int'(output_0_aktv); a1_cnt += int'(output_1_aktv);
    en0_cnt += int'(enable_in0);
    if (q_push && !q_push_valid) saw_drop = 1'b1;
    if (r) begin
      mq.delete(); fl.delete();
      m_o0 = 0; m_o1 = 0; m_cnt = 0; m_e = 0;
    end else if (e) begin
      foreach (fl[i]) begin
        age = m_e - fl[i].pop_e;
        if (age == 1 && fl[i].ent.has_event) m_o0 = fl[i].ent.data + m_o1;
        if (age == 2 && fl[i].ent.has_tick) m_o1 = m_o0 + 64'd1;
        if (age < 3) keep.push_back(fl[i]);
      end
      fl = keep;
      if (x_pop) begin
        f.ent = mq.pop_front();
        f.pop_e = m_e;
        fl.push_back(f);
      end
      if (x_pushv) begin
`ifdef TOPENTITY_DROP_OLDEST_EN
        if (mq.size() == int'(DEPTH)) ent = mq.pop_front();
`endif
        ent.has_event = nv; ent.data = d; ent.has_tick = tk;
        mq.push_back(ent);
      end
      m_cnt = tk ? 0 : m_cnt + 1;
      m_e++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1, 1'b0, 64'd0);
  endtask

  task automatic ev(input logic [63:0] d);
    step(1'b0, 1'b1, 1'b1, d);
  endtask

  // Advance until the next enabled cycle is the tick cycle.
  task automatic to_tick();
    for (int g = 0; g < int'(PERIOD) + 2 && m_cnt != int'(PERIOD) - 1; g++) idle(1);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; a0_cnt = 0; a1_cnt = 0; en0_cnt = 0; saw_drop = 1'b0;
    mq.delete(); fl.delete(); m_o0 = 0; m_o1 = 0; m_cnt = 0; m_e = 0;
    rst = 1'b1; en = 1'b0; new_input_0 = 1'b0; input_0 = '0;
    repeat (2) @(posedge clk);
    #1;
    step(1'b1, 1'b1, 1'b0, 64'd0);
    chk("reset_o0", l_o0, 64'd0);
    chk("reset_o1", l_o1, 64'd0);
    chk("reset_aktv", {l_a0, l_a1}, 2'b00);

    ev(64'd1); idle(4);
    chk("ev1_aktv", {l_a0, l_a1}, 2'b10);
    chk("ev1_o0", l_o0, 64'd1);
    chk("ev1_o1", l_o1, 64'd0);

    to_tick(); idle(1); idle(4);
    chk("tick1_aktv", {l_a0, l_a1}, 2'b01);
    chk("tick1_o1", l_o1, 64'd2);
    ev(64'd2); idle(4);
    chk("ev2_aktv", {l_a0, l_a1}, 2'b10);
    chk("ev2_o0", l_o0, 64'd4);

    to_tick(); ev(64'd3); idle(4);
    chk("both_aktv", {l_a0, l_a1}, 2'b11);
    chk("both_o0", l_o0, 64'd5);
    chk("both_o1", l_o1, 64'd6);

    a0_cnt = 0; en0_cnt = 0;
    ev(64'd1); ev(64'd2); ev(64'd3); ev(64'd4); idle(12);
    chk("burst4_aktv_count", a0_cnt, 4);
    chk("burst4_en_count", en0_cnt, 4);
    chk("burst4_last_o0", l_o0, 64'd10);

    saw_drop = 1'b0;
    for (int k = 0; k < 8; k++) ev(64'(10 + k));
    idle(30);
`ifdef TOPENTITY_DROP_OLDEST_EN
    chk("burst8_drop_seen", saw_drop, 1'b0);
`else
    chk("burst8_drop_seen", saw_drop, 1'b1);
`endif
    chk("burst8_last_o0", l_o0, 64'd23);

    for (int blk = 0; blk < 15; blk++) begin
      for (int i = 0; i < 200; i++) begin
        r_l  = ($urandom_range(0, 399) == 0);
        e_l  = ($urandom_range(0, 9) != 0);
        nv_l = blk[0] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
        step(r_l, e_l, nv_l, {$urandom(), $urandom()});
      end
    end

    step(1'b1, 1'b1, 1'b0, 64'd0);
    ev(64'd100); ev(64'd101); ev(64'd102); ev(64'd103);
    step(1'b1, 1'b1, 1'b0, 64'd0);
    idle(1);
    chk("midrst_o0", l_o0, 64'd0);
    chk("midrst_o1", l_o1, 64'd0);
    chk("midrst_aktv", {l_a0, l_a1}, 2'b00);
    a0_cnt = 0; a1_cnt = 0;
    idle(10);
    chk("midrst_no_aktv", a0_cnt + a1_cnt, 0);
    ev(64'd7); idle(4);
    chk("after_rst_aktv", {l_a0, l_a1}, 2'b10);
    chk("after_rst_o0", l_o0, 64'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
